// File: rtl/rv_mc_controller.sv
// rv_mc_controller
// Multicycle RV32I control FSM for a shared-ALU datapath. It sequences
// fetch / decode / execute / memory / writeback for each instruction and
// drives every datapath enable and mux select, plus the ALU operation code.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; forces FETCH, clears illegal
//   op         in   [6:0] instr[6:0]
//   funct3     in   [2:0] instr[14:12]
//   funct7b5   in   instr[30]
//   zero       in   ALU result == 0
//   mem_ready  in   memory accepted the access / read data valid
//   pcwrite    out  PC load enable
//   adrsrc     out  memory address: 0 = PC, 1 = Result
//   memwrite   out  memory write request
//   irwrite    out  IR/OldPC load enable
//   regwrite   out  register file write enable
//   resultsrc  out  [1:0] 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
//   alusrca    out  [1:0] 00 PC, 01 OldPC, 10 rs1
//   alusrcb    out  [1:0] 00 rs2, 01 ImmExt, 10 constant 4
//   immsrc     out  [2:0] 000 I, 001 S, 010 B, 011 J, 100 U
//   alucontrol out  [3:0] ALU operation (see localparams below)
//   illegal    out  sticky flag: an unsupported instruction was decoded
module rv_mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       adrsrc,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic [1:0] resultsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] immsrc,
   output logic [3:0] alucontrol,
   output logic       illegal
);

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
      ALUWB, BRANCH, JAL, JALR, LINK, LUI, TRAP
   } state_t;

   state_t state, state_next;

   // ALU op for register and immediate arithmetic; SUB exists only for
   // R-type, while the shift-right arithmetic bit applies to both forms.
   function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                             input logic       f7b5,
                                             input logic       is_r);
      unique case (f3)
         3'b000:  alu_decode = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_decode = ALU_SLL;
         3'b010:  alu_decode = ALU_SLT;
         3'b011:  alu_decode = ALU_SLTU;
         3'b100:  alu_decode = ALU_XOR;
         3'b101:  alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_decode = ALU_OR;
         default: alu_decode = ALU_AND;
      endcase
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   illegal <= 1'b0;
      else if (state_next == TRAP) illegal <= 1'b1;
   end

   always_comb begin
      // NOTE: every output is given a default before the case statement so
      // no path through this block can leave a signal unassigned (latch).
      state_next = state;
      pcwrite    = 1'b0;
      adrsrc     = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      resultsrc  = 2'b00;
      alusrca    = 2'b00;
      alusrcb    = 2'b00;
      alucontrol = ALU_ADD;

      unique case (op)
         OP_LOAD, OP_I, OP_JALR: immsrc = 3'b000;
         OP_STORE:               immsrc = 3'b001;
         OP_BRANCH:              immsrc = 3'b010;
         OP_JAL:                 immsrc = 3'b011;
         OP_LUI, OP_AUIPC:       immsrc = 3'b100;
         default:                immsrc = 3'b000;
      endcase

      unique case (state)
         FETCH: begin
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            irwrite   = mem_ready;
            pcwrite   = mem_ready;
            if (mem_ready) state_next = DECODE;
         end
         DECODE: begin
            // OldPC + imm is parked in ALUOut as the branch target.
            alusrca = 2'b01;
            alusrcb = 2'b01;
            unique case (op)
               OP_LOAD, OP_STORE: state_next = MEMADR;
               OP_R:              state_next = EXECR;
               OP_I:              state_next = EXECI;
               OP_BRANCH:         state_next = BRANCH;
               OP_JAL:            state_next = JAL;
               OP_JALR:           state_next = JALR;
               OP_LUI:            state_next = LUI;
               OP_AUIPC:          state_next = ALUWB;
               default:           state_next = TRAP;
            endcase
         end
         MEMADR: begin
            alusrca    = 2'b10;
            alusrcb    = 2'b01;
            state_next = (op == OP_STORE) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adrsrc = 1'b1;
            if (mem_ready) state_next = MEMWB;
         end
         MEMWB: begin
            resultsrc  = 2'b01;
            regwrite   = 1'b1;
            state_next = FETCH;
         end
         MEMWRITE: begin
            adrsrc   = 1'b1;
            memwrite = 1'b1;
            if (mem_ready) state_next = FETCH;
         end
         EXECR: begin
            alusrca    = 2'b10;
            alucontrol = alu_decode(funct3, funct7b5, 1'b1);
            state_next = ALUWB;
         end
         EXECI: begin
            alusrca    = 2'b10;
            alusrcb    = 2'b01;
            alucontrol = alu_decode(funct3, funct7b5, 1'b0);
            state_next = ALUWB;
         end
         ALUWB: begin
            regwrite   = 1'b1;
            state_next = FETCH;
         end
         BRANCH: begin
            // SLT/SLTU leave zero set when the "less than" test is false.
            alusrca    = 2'b10;
            state_next = FETCH;
            unique case (funct3)
               3'b000: begin alucontrol = ALU_SUB;  pcwrite = zero;  end
               3'b001: begin alucontrol = ALU_SUB;  pcwrite = !zero; end
               3'b100: begin alucontrol = ALU_SLT;  pcwrite = !zero; end
               3'b101: begin alucontrol = ALU_SLT;  pcwrite = zero;  end
               3'b110: begin alucontrol = ALU_SLTU; pcwrite = !zero; end
               3'b111: begin alucontrol = ALU_SLTU; pcwrite = zero;  end
               default: state_next = TRAP;
            endcase
         end
         JAL: begin
            pcwrite    = 1'b1;
            alusrca    = 2'b01;
            alusrcb    = 2'b10;
            state_next = ALUWB;
         end
         JALR: begin
            alusrca    = 2'b10;
            alusrcb    = 2'b01;
            resultsrc  = 2'b10;
            pcwrite    = 1'b1;
            state_next = LINK;
         end
         LINK: begin
            alusrca    = 2'b01;
            alusrcb    = 2'b10;
            state_next = ALUWB;
         end
         LUI: begin
            resultsrc  = 2'b11;
            regwrite   = 1'b1;
            state_next = FETCH;
         end
         TRAP:    state_next = TRAP;
         default: state_next = FETCH;
      endcase

      // Write enables must not reach the datapath while reset is held, even
      // though the state register is already forced to FETCH.
      if (reset) begin
         pcwrite  = 1'b0;
         memwrite = 1'b0;
         irwrite  = 1'b0;
         regwrite = 1'b0;
      end
   end

endmodule

// File: tb/tb_rv_mc_controller.sv
// Directed bench for rv_mc_controller. All 19 control outputs are packed
// into one vector and compared against hand-written expectations per cycle.
module tb_rv_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
   logic [1:0] resultsrc, alusrca, alusrcb;
   logic [2:0] immsrc;
   logic [3:0] alucontrol;

   int passed = 0;
   int total  = 0;

   rv_mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite), .adrsrc(adrsrc),
      .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
      .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
      .immsrc(immsrc), .alucontrol(alucontrol), .illegal(illegal)
   );

   always #5 clk = ~clk;

   logic [18:0] obs;
   assign obs = {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
                 alusrca, alusrcb, immsrc, alucontrol, illegal};

   // Packs expected control fields in the same order as obs.
   function automatic logic [18:0] ctl(input logic pcw, input logic adr,
                                       input logic mw, input logic irw,
                                       input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] imm, input logic [3:0] alu,
                                       input logic ill);
      return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
   endfunction

   task automatic check(input string tag, input logic [18:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
   endtask

   // Advance one clock; land mid-cycle so inputs change away from edges.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      op = o; funct3 = f3; funct7b5 = f7;
   endtask

   initial begin
      reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
      #12;
      // In reset: state FETCH but every enable gated off.
      check("reset_hold", ctl(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,4'b0000,0));
      reset = 1'b0;

      // add x, f7b5=0: FETCH, DECODE, EXECR, ALUWB, then next FETCH.
      set_instr(7'b0110011, 3'b000, 1'b0); #1;
      check("add_fetch",  ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,4'b0000,0));
      tick(); check("add_decode", ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,4'b0000,0));
      tick(); check("add_execr",  ctl(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0000,0));
      tick(); check("add_aluwb",  ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,4'b0000,0));
      tick(); check("add_cpi4",   ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,4'b0000,0));

      // sub: same sequence, alucontrol 0001.
      funct7b5 = 1'b1;
      tick(); tick(); #1;
      check("sub_execr", ctl(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0));
      tick(); tick();

      // srai.
      set_instr(7'b0010011, 3'b101, 1'b1);
      tick(); tick(); #1;
      check("srai_execi", ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b1001,0));
      tick(); check("srai_aluwb", ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,4'b0000,0));
      tick();

      // addi with funct7b5 = 1 must remain ADD.
      set_instr(7'b0010011, 3'b000, 1'b1);
      tick(); tick(); #1;
      check("addi_f7_execi", ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0000,0));
      tick(); tick();

      // FETCH stalls while mem_ready is low.
      set_instr(7'b0000011, 3'b010, 1'b0);
      mem_ready = 1'b0; #1;
      check("fetch_stall", ctl(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,4'b0000,0));
      tick(); check("fetch_stall2", ctl(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,4'b0000,0));
      mem_ready = 1'b1;

      // lw with three wait cycles in MEMREAD.
      tick();
      tick(); mem_ready = 1'b0; #1;
      check("lw_memadr", ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0000,0));
      for (int i = 0; i < 3; i++) begin
         tick(); check("lw_memread_wait", ctl(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,0));
      end
      tick(); mem_ready = 1'b1; #1;
      check("lw_memread_ready", ctl(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,0));
      tick(); check("lw_memwb", ctl(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,4'b0000,0));
      tick(); check("lw_next_fetch", ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,4'b0000,0));

      // sw: memwrite held through the mem_ready cycle.
      set_instr(7'b0100011, 3'b010, 1'b0);
      tick(); tick(); mem_ready = 1'b0;
      tick(); check("sw_memwrite_wait", ctl(0,1,1,0,0,2'b00,2'b00,2'b00,3'b001,4'b0000,0));
      tick(); check("sw_memwrite_wait2", ctl(0,1,1,0,0,2'b00,2'b00,2'b00,3'b001,4'b0000,0));
      mem_ready = 1'b1; #1;
      check("sw_memwrite_ready", ctl(0,1,1,0,0,2'b00,2'b00,2'b00,3'b001,4'b0000,0));
      tick(); check("sw_next_fetch", ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b001,4'b0000,0));

      // beq: taken with zero=1, not taken with zero=0 (same cycle).
      set_instr(7'b1100011, 3'b000, 1'b0); zero = 1'b1;
      tick(); tick(); #1;
      check("beq_taken", ctl(1,0,0,0,0,2'b00,2'b10,2'b00,3'b010,4'b0001,0));
      zero = 1'b0; #1;
      check("beq_not_taken", ctl(0,0,0,0,0,2'b00,2'b10,2'b00,3'b010,4'b0001,0));
      tick(); check("beq_next_fetch", ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b010,4'b0000,0));

      // bge with zero=0: not taken, SLT.
      funct3 = 3'b101;
      tick(); tick(); #1;
      check("bge_zero0", ctl(0,0,0,0,0,2'b00,2'b10,2'b00,3'b010,4'b0101,0));
      tick();

      // bltu with zero=0: taken, SLTU.
      funct3 = 3'b110;
      tick(); tick(); #1;
      check("bltu_zero0", ctl(1,0,0,0,0,2'b00,2'b10,2'b00,3'b010,4'b0110,0));
      tick();

      // jal: JAL then ALUWB.
      set_instr(7'b1101111, 3'b000, 1'b0);
      tick(); tick(); #1;
      check("jal_state", ctl(1,0,0,0,0,2'b00,2'b01,2'b10,3'b011,4'b0000,0));
      tick(); check("jal_aluwb", ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b011,4'b0000,0));
      tick();

      // jalr: JALR, LINK, ALUWB.
      set_instr(7'b1100111, 3'b000, 1'b0);
      tick(); tick(); #1;
      check("jalr_state", ctl(1,0,0,0,0,2'b10,2'b10,2'b01,3'b000,4'b0000,0));
      tick(); check("jalr_link", ctl(0,0,0,0,0,2'b00,2'b01,2'b10,3'b000,4'b0000,0));
      tick(); check("jalr_aluwb", ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,4'b0000,0));
      tick();

      // lui.
      set_instr(7'b0110111, 3'b000, 1'b0);
      tick(); tick(); #1;
      check("lui_state", ctl(0,0,0,0,1,2'b11,2'b00,2'b00,3'b100,4'b0000,0));
      tick(); check("lui_next_fetch", ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b100,4'b0000,0));

      // Illegal opcode: TRAP, sticky, no enables even with mem_ready high.
      set_instr(7'b0000000, 3'b000, 1'b0);
      tick(); tick(); #1;
      check("trap_entry", ctl(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,1));
      tick(); tick(); check("trap_sticky", ctl(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,1));
      reset = 1'b1; #1;
      check("trap_reset", ctl(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,4'b0000,0));
      tick(); reset = 1'b0; #1;
      check("trap_release_fetch", ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,4'b0000,0));

      // Reset mid-MEMWRITE: memwrite drops at once, FETCH after release.
      set_instr(7'b0100011, 3'b010, 1'b0);
      tick(); tick(); mem_ready = 1'b0;
      tick(); check("rst_sw_memwrite", ctl(0,1,1,0,0,2'b00,2'b00,2'b00,3'b001,4'b0000,0));
      reset = 1'b1; #1;
      check("rst_sw_drop", ctl(0,0,0,0,0,2'b10,2'b00,2'b10,3'b001,4'b0000,0));
      tick(); reset = 1'b0; mem_ready = 1'b1; #1;
      check("rst_sw_fetch", ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b001,4'b0000,0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
